// File: rtl/pattern_sequencer.sv
// Multi-channel LED pattern sequencer: loadable per-channel patterns played at a
// programmable step rate, with loop/one-shot modes, pause, restart and deferred loads.
module pattern_sequencer #(
  parameter int          N_CH        = 1,
  parameter int          PAT_LEN     = 32,
  parameter int          DIV_W       = 24,
  parameter logic [31:0] DEFAULT_PAT = 32'h0000AAAB,
  parameter bit          AUTOSTART   = 1'b0,
  parameter bit          LED_INV     = 1'b0,
  localparam int         CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int         IDX_W       = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1,
  localparam int         LEN_W       = $clog2(PAT_LEN + 1)
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic               EN,
  input  logic               MODE,
  input  logic [DIV_W-1:0]   STEP_DIV,
  input  logic               LD_VALID,
  output logic               LD_READY,
  input  logic [CH_W-1:0]    LD_CH,
  input  logic [PAT_LEN-1:0] LD_PAT,
  input  logic [LEN_W-1:0]   LD_LEN,
  output logic [N_CH-1:0]    LED,
  output logic [IDX_W-1:0]   STEP_IDX,
  output logic               DONE,
  output logic               USBPU
);

  // state   | meaning
  // S_IDLE  | stopped, LEDs inactive, waiting for START
  // S_RUN   | stepping through the pattern on prescaler ticks
  // S_PAUSE | prescaler and step index frozen, LEDs hold
  // S_DONE  | one-shot finished, LEDs inactive, DONE asserted
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

  localparam logic [PAT_LEN-1:0] RST_PAT = PAT_LEN'(DEFAULT_PAT);

  state_t             state, state_n;
  logic [IDX_W-1:0]   idx, idx_n;
  logic [DIV_W-1:0]   presc, presc_n;
  logic [PAT_LEN-1:0] pat [N_CH];
  logic [LEN_W-1:0]   len;
  logic               pending;
  logic [CH_W-1:0]    sh_ch;
  logic [PAT_LEN-1:0] sh_pat;
  logic [LEN_W-1:0]   sh_len;
  logic [LEN_W-1:0]   ld_len_c;
  logic               tick, last, commit, accept;

  assign USBPU    = 1'b0;
  assign LD_READY = !pending;
  assign tick     = (presc >= STEP_DIV);
  assign last     = ((LEN_W'(idx) + LEN_W'(1)) >= len);
  // Out-of-range channels complete the handshake but never become pending.
  assign accept   = LD_VALID && !pending && (32'(LD_CH) < N_CH);

  always_comb begin
    ld_len_c = LD_LEN;
    if (LD_LEN == '0)                    ld_len_c = LEN_W'(1);
    else if (LD_LEN > LEN_W'(PAT_LEN))   ld_len_c = LEN_W'(PAT_LEN);
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    presc_n = presc;
    commit  = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        commit = pending;
        if (START) begin
          state_n = EN ? S_RUN : S_PAUSE;
          idx_n   = '0;
          presc_n = '0;
        end
      end
      S_RUN: begin
        if (START) begin
          commit  = pending;
          state_n = EN ? S_RUN : S_PAUSE;
          idx_n   = '0;
          presc_n = '0;
        end else begin
          // The cycle in which EN drops still counts toward the current step.
          if (!EN) state_n = S_PAUSE;
          if (tick) begin
            presc_n = '0;
            if (!last) begin
              idx_n = idx + 1'b1;
            end else if (!MODE) begin
              idx_n  = '0;
              commit = pending;
            end else begin
              idx_n   = '0;
              state_n = S_DONE;
            end
          end else begin
            presc_n = presc + 1'b1;
          end
        end
      end
      S_PAUSE: begin
        commit = pending;
        if (START) begin
          state_n = EN ? S_RUN : S_PAUSE;
          idx_n   = '0;
          presc_n = '0;
        end else begin
          if (EN) state_n = S_RUN;
          if (pending && (LEN_W'(idx) >= sh_len)) idx_n = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= AUTOSTART ? S_RUN : S_IDLE;
      idx      <= '0;
      presc    <= '0;
      len      <= LEN_W'(PAT_LEN);
      pending  <= 1'b0;
      sh_ch    <= '0;
      sh_pat   <= '0;
      sh_len   <= '0;
      for (int c = 0; c < N_CH; c++) pat[c] <= RST_PAT;
      LED      <= {N_CH{LED_INV}};
      STEP_IDX <= '0;
      DONE     <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      presc <= presc_n;
      if (accept) begin
        pending <= 1'b1;
        sh_ch   <= LD_CH;
        sh_pat  <= LD_PAT;
        sh_len  <= ld_len_c;
      end else if (commit) begin
        pending <= 1'b0;
      end
      if (commit) len <= sh_len;
      for (int c = 0; c < N_CH; c++) begin
        if (commit && (sh_ch == CH_W'(c))) pat[c] <= sh_pat;
      end
      // Outputs trail the step index by one cycle so LED and STEP_IDX stay aligned.
      if (state == S_RUN || state == S_PAUSE) begin
        for (int c = 0; c < N_CH; c++) LED[c] <= pat[c][idx] ^ LED_INV;
        STEP_IDX <= idx;
      end else begin
        LED      <= {N_CH{LED_INV}};
        STEP_IDX <= '0;
      end
      DONE <= (state == S_DONE);
    end
  end

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer: playback, one-shot, pause, live load,
// reset with pending load, restart-on-tick, STEP_DIV=0, autostart and bad channel.
module tb_pattern_sequencer;

  logic       clk = 1'b0;
  logic       rst, start, en, mode, ld_valid, ld_ch;
  logic [7:0] step_div, ld_pat;
  logic [3:0] ld_len;
  logic       ld_ready, done, usbpu;
  logic [1:0] led;
  logic [2:0] step_idx;

  logic       b_rst, b_start, b_en, b_mode, b_ld_valid;
  logic [1:0] b_ld_ch;
  logic [7:0] b_step_div, b_ld_pat;
  logic [3:0] b_ld_len;
  logic       b_ld_ready, b_done, b_usbpu;
  logic [2:0] b_led, b_step_idx;

  int checks = 0;
  int failures = 0;

  logic [7:0] p0   = 8'b10110010;
  logic [7:0] dflt = 8'hAB;

  always #5 clk = ~clk;

  pattern_sequencer #(.N_CH(2), .PAT_LEN(8), .DIV_W(8), .AUTOSTART(1'b0)) dut (
    .CLK(clk), .RST(rst), .START(start), .EN(en), .MODE(mode), .STEP_DIV(step_div),
    .LD_VALID(ld_valid), .LD_READY(ld_ready), .LD_CH(ld_ch), .LD_PAT(ld_pat),
    .LD_LEN(ld_len), .LED(led), .STEP_IDX(step_idx), .DONE(done), .USBPU(usbpu));

  pattern_sequencer #(.N_CH(3), .PAT_LEN(8), .DIV_W(8), .AUTOSTART(1'b1)) dut_b (
    .CLK(clk), .RST(b_rst), .START(b_start), .EN(b_en), .MODE(b_mode), .STEP_DIV(b_step_div),
    .LD_VALID(b_ld_valid), .LD_READY(b_ld_ready), .LD_CH(b_ld_ch), .LD_PAT(b_ld_pat),
    .LD_LEN(b_ld_len), .LED(b_led), .STEP_IDX(b_step_idx), .DONE(b_done), .USBPU(b_usbpu));

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; en = 1; mode = 0; step_div = 8'd3;
    ld_valid = 0; ld_ch = 0; ld_pat = 0; ld_len = 0;
    b_rst = 1; b_start = 0; b_en = 1; b_mode = 0; b_step_div = 8'd3;
    b_ld_valid = 0; b_ld_ch = 0; b_ld_pat = 0; b_ld_len = 0;

    // Reset values and staying idle without START
    cyc(2);
    rst = 0; b_rst = 0;
    cyc(1);
    chk("rst_led", led, 2'b00);
    chk("rst_done", done, 1'b0);
    chk("rst_ready", ld_ready, 1'b1);
    chk("rst_idx", step_idx, 3'd0);
    chk("rst_usbpu", usbpu, 1'b0);
    cyc(5);
    chk("idle_led", led, 2'b00);
    chk("idle_idx", step_idx, 3'd0);

    // Loop playback: ch0 loaded, ch1 default
    ld_valid = 1; ld_ch = 0; ld_pat = p0; ld_len = 4'd8;
    cyc(1);
    ld_valid = 0;
    chk("load_ready_low", ld_ready, 1'b0);
    cyc(1);
    chk("load_ready_back", ld_ready, 1'b1);
    start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    for (int k = 0; k < 64; k++) begin
      chk("loop_idx", step_idx, 32'((k / 4) % 8));
      chk("loop_led", led, {dflt[(k / 4) % 8], p0[(k / 4) % 8]});
      cyc(1);
    end

    // Pause during the second cycle of step 3
    start = 1;
    cyc(1);
    start = 0;
    cyc(13);
    en = 0;
    cyc(2);
    chk("pause_idx_a", step_idx, 3'd3);
    chk("pause_led_a", led, 2'b10);
    cyc(8);
    chk("pause_idx_b", step_idx, 3'd3);
    chk("pause_led_b", led, 2'b10);
    en = 1;
    cyc(2);
    chk("resume_idx_1", step_idx, 3'd3);
    cyc(1);
    chk("resume_idx_2", step_idx, 3'd3);
    cyc(1);
    chk("resume_idx_3", step_idx, 3'd4);
    chk("resume_led", led, 2'b01);

    // Live load of ch1 while running, deferred to the wrap
    start = 1;
    cyc(1);
    start = 0;
    cyc(8);
    ld_valid = 1; ld_ch = 1; ld_pat = 8'hFF; ld_len = 4'd8;
    cyc(1);
    chk("live_ready_low", ld_ready, 1'b0);
    ld_pat = 8'h00;
    cyc(2);
    chk("live_stall", ld_ready, 1'b0);
    ld_valid = 0;
    cyc(14);
    chk("live_not_yet", led, 2'b00);
    cyc(6);
    chk("live_pending", ld_ready, 1'b0);
    cyc(1);
    chk("live_ready_wrap", ld_ready, 1'b1);
    chk("live_led7", led, 2'b11);
    cyc(1);
    chk("live_wrap_idx", step_idx, 3'd0);
    chk("live_wrap_led", led, 2'b10);
    cyc(8);
    chk("live_led2", led, 2'b10);

    // START coincident with the wrap tick at idx 7
    cyc(22);
    start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    chk("start_tick_a", step_idx, 3'd0);
    cyc(3);
    chk("start_tick_b", step_idx, 3'd0);
    cyc(1);
    chk("start_tick_c", step_idx, 3'd1);

    // Reset while a load is pending
    ld_valid = 1; ld_ch = 0; ld_pat = 8'h0F; ld_len = 4'd5;
    cyc(1);
    ld_valid = 0;
    chk("rst_pend_ready", ld_ready, 1'b0);
    rst = 1;
    cyc(1);
    rst = 0;
    chk("rst2_ready", ld_ready, 1'b1);
    chk("rst2_led", led, 2'b00);
    chk("rst2_idx", step_idx, 3'd0);
    chk("rst2_done", done, 1'b0);
    cyc(3);
    chk("rst2_idle", step_idx, 3'd0);
    start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    for (int k = 0; k < 36; k++) begin
      chk("dflt_idx", step_idx, 32'((k / 4) % 8));
      chk("dflt_led", led, {dflt[(k / 4) % 8], dflt[(k / 4) % 8]});
      cyc(1);
    end

    // One-shot with length 5, loaded while paused
    en = 0;
    ld_valid = 1; ld_ch = 0; ld_pat = p0; ld_len = 4'd5;
    cyc(1);
    ld_valid = 0;
    cyc(1);
    chk("pause_commit", ld_ready, 1'b1);
    mode = 1; en = 1; start = 1;
    cyc(1);
    start = 0;
    cyc(20);
    chk("os_done_lo", done, 1'b0);
    chk("os_last_idx", step_idx, 3'd4);
    chk("os_last_led", led, 2'b01);
    cyc(1);
    chk("os_done_hi", done, 1'b1);
    chk("os_led_off", led, 2'b00);
    chk("os_idx0", step_idx, 3'd0);
    cyc(50);
    chk("os_done_hold", done, 1'b1);
    chk("os_led_hold", led, 2'b00);
    start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    chk("os_restart_done", done, 1'b0);
    chk("os_restart_idx", step_idx, 3'd0);
    chk("os_restart_led", led, 2'b10);
    cyc(4);
    chk("os_restart_step", step_idx, 3'd1);

    // STEP_DIV = 0 in loop mode with length 5
    mode = 0; step_div = 8'd0; start = 1;
    cyc(1);
    start = 0;
    cyc(1);
    for (int k = 0; k < 10; k++) begin
      chk("div0_idx", step_idx, 32'(k % 5));
      chk("div0_led", led, {dflt[k % 5], p0[k % 5]});
      cyc(1);
    end

    // Autostart instance, plus a load aimed at a non-existent channel
    b_rst = 1;
    cyc(1);
    b_rst = 0;
    cyc(1);
    chk("b_usbpu", b_usbpu, 1'b0);
    for (int k = 0; k < 40; k++) begin
      chk("auto_idx", b_step_idx, 32'((k / 4) % 8));
      chk("auto_led", b_led, {3{dflt[(k / 4) % 8]}});
      cyc(1);
    end
    b_ld_valid = 1; b_ld_ch = 2'd3; b_ld_pat = 8'h00; b_ld_len = 4'd1;
    cyc(1);
    b_ld_valid = 0;
    chk("badch_ready", b_ld_ready, 1'b1);
    for (int k = 41; k < 72; k++) begin
      chk("badch_idx", b_step_idx, 32'((k / 4) % 8));
      chk("badch_led", b_led, {3{dflt[(k / 4) % 8]}});
      chk("badch_done", b_done, 1'b0);
      cyc(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
